// File: rtl/phase_vec_sram_ctrl.sv
// Phase-vector / transfer-function coefficient SRAM controller: two banks of DEPTH words,
// sequential load from a deserializer, sequential debug readback, dual-port random reads.
module phase_vec_sram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  debug,
  input  logic                  debug_read_trig,
  input  logic                  load,
  input  logic                  wdata_valid,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  ren,
  input  logic                  rwen,
  input  logic [ADDR_WIDTH-1:0] radr,
  input  logic [ADDR_WIDTH-1:0] rwadr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] rwdata
);

  localparam int ROW_W = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(2 * DEPTH - 1);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_DEBUG  = 2'd1,
    MODE_LOAD   = 2'd2
  } mode_e;

  logic [DATA_WIDTH-1:0] bank0_mem [DEPTH];
  logic [DATA_WIDTH-1:0] bank1_mem [DEPTH];

  mode_e                 mode;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] dptr_q, dptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] rwdata_q, rwdata_d;
  logic [ADDR_WIDTH-1:0] ro_adr;
  logic [DATA_WIDTH-1:0] ro_word, rw_word;
  logic                  wr_en;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mode = MODE_NORMAL;
    if (load) begin
      mode = MODE_LOAD;
    end else if (debug) begin
      mode = MODE_DEBUG;
    end
  end

  // The R/O port is shared between debug readback and normal random reads.
  assign ro_adr  = (mode == MODE_DEBUG) ? dptr_q : radr;
  assign ro_word = ro_adr[ADDR_WIDTH-1] ? bank1_mem[ro_adr[ROW_W-1:0]]
                                        : bank0_mem[ro_adr[ROW_W-1:0]];
  assign rw_word = rwadr[ADDR_WIDTH-1] ? bank1_mem[rwadr[ROW_W-1:0]]
                                       : bank0_mem[rwadr[ROW_W-1:0]];
  assign wr_en   = (mode == MODE_LOAD) && wdata_valid;

  always_comb begin
    wptr_d   = '0;
    dptr_d   = '0;
    rdata_d  = rdata_q;
    rwdata_d = rwdata_q;

    if (load) begin
      wptr_d = wdata_valid ? next_ptr(wptr_q) : wptr_q;
    end

    // Debug pointer survives a load interruption but resets whenever debug drops.
    if (debug) begin
      dptr_d = ((mode == MODE_DEBUG) && debug_read_trig) ? next_ptr(dptr_q) : dptr_q;
    end

    case (mode)
      MODE_DEBUG: begin
        rdata_d = ro_word;
      end
      MODE_NORMAL: begin
        if (ren) begin
          rdata_d = ro_word;
        end
        if (rwen) begin
          rwdata_d = rw_word;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      dptr_q   <= '0;
      rdata_q  <= '0;
      rwdata_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      dptr_q   <= dptr_d;
      rdata_q  <= rdata_d;
      rwdata_q <= rwdata_d;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wptr_q[ADDR_WIDTH-1]) begin
        bank1_mem[wptr_q[ROW_W-1:0]] <= wdata_in;
      end else begin
        bank0_mem[wptr_q[ROW_W-1:0]] <= wdata_in;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rwdata = rwdata_q;

endmodule

// File: tb/tb_phase_vec_sram_ctrl.sv
// Self-checking bench for phase_vec_sram_ctrl: full load, debug readback, dual-port reads,
// wrap-around load, mode toggling and reset in the middle of a load.
module tb_phase_vec_sram_ctrl;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int N  = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          debug = 1'b0;
  logic          debug_read_trig = 1'b0;
  logic          load = 1'b0;
  logic          wdata_valid = 1'b0;
  logic [DW-1:0] wdata_in = '0;
  logic          ren = 1'b0;
  logic          rwen = 1'b0;
  logic [AW-1:0] radr = '0;
  logic [AW-1:0] rwadr = '0;
  logic [DW-1:0] rdata;
  logic [DW-1:0] rwdata;

  logic [DW-1:0] model [N];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          ren;
    logic          rwen;
    logic [AW-1:0] radr;
    logic [AW-1:0] rwadr;
    logic [DW-1:0] exp_r;
    logic [DW-1:0] exp_rw;
  } vec_t;

  vec_t vecs [7];

  phase_vec_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(N/2)) dut (
    .clk(clk), .rst_n(rst_n), .debug(debug), .debug_read_trig(debug_read_trig),
    .load(load), .wdata_valid(wdata_valid), .wdata_in(wdata_in),
    .ren(ren), .rwen(rwen), .radr(radr), .rwadr(rwadr),
    .rdata(rdata), .rwdata(rwdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int errs;
    int first_bad;

    for (int i = 0; i < N; i++) model[i] = DW'($urandom);

    // Reset
    #2 rst_n = 1'b0;
    step();
    step();
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_rwdata", 32'(rwdata), 32'h0);
    rst_n = 1'b1;
    step();

    // Full load with occasional idle cycles
    load = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i % 7 == 3) begin
        wdata_valid = 1'b0;
        wdata_in    = 16'hFFFF;
        step();
      end
      wdata_valid = 1'b1;
      wdata_in    = model[i];
      step();
    end
    wdata_valid = 1'b0;
    check("load_hold_rdata", 32'(rdata), 32'h0);

    // Debug readback, serializer starts two cycles after debug rises
    load  = 1'b0;
    debug = 1'b1;
    step();
    step();
    errs = 0;
    first_bad = -1;
    for (int i = 0; i < N; i++) begin
      if (rdata !== model[i]) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      debug_read_trig = 1'b1;
      step();
      debug_read_trig = 1'b0;
      step();
    end
    if (errs != 0) $display("first debug stream error at word %0d", first_bad);
    check("debug_stream_errors", 32'(errs), 32'h0);
    check("debug_wrap", 32'(rdata), 32'(model[0]));
    check("debug_rwdata_hold", 32'(rwdata), 32'h0);

    for (int i = 0; i < 5; i++) begin
      debug_read_trig = 1'b1;
      step();
      debug_read_trig = 1'b0;
      step();
    end
    check("debug_mid", 32'(rdata), 32'(model[5]));
    debug = 1'b0;
    step();
    debug = 1'b1;
    step();
    step();
    check("debug_restart", 32'(rdata), 32'(model[0]));
    debug = 1'b0;

    // Normal mode dual-port sweep
    ren  = 1'b1;
    rwen = 1'b1;
    errs = 0;
    for (int i = 0; i < N; i++) begin
      radr  = AW'(i);
      rwadr = AW'(N - 1 - i);
      step();
      if (rdata !== model[i] || rwdata !== model[N-1-i]) errs++;
    end
    check("normal_sweep_errors", 32'(errs), 32'h0);

    // wdata_valid outside load mode must not write
    radr        = '0;
    rwadr       = '0;
    wdata_valid = 1'b1;
    wdata_in    = ~model[0];
    step();
    step();
    step();
    wdata_valid = 1'b0;
    step();
    check("wvalid_ignored", 32'(rdata), 32'(model[0]));

    // Table-driven normal-mode vectors (state entering: rdata=rwdata=model[0])
    vecs[0] = '{1'b1, 1'b1, 12'h805, 12'h805, model[12'h805], model[12'h805]};
    vecs[1] = '{1'b0, 1'b1, 12'h123, 12'h000, model[12'h805], model[0]};
    vecs[2] = '{1'b1, 1'b0, 12'h7FF, 12'h800, model[12'h7FF], model[0]};
    vecs[3] = '{1'b1, 1'b1, 12'h000, 12'hFFF, model[0], model[12'hFFF]};
    vecs[4] = '{1'b0, 1'b0, 12'h555, 12'h666, model[0], model[12'hFFF]};
    vecs[5] = '{1'b1, 1'b1, 12'h801, 12'h001, model[12'h801], model[1]};
    vecs[6] = '{1'b1, 1'b1, 12'h001, 12'h801, model[1], model[12'h801]};
    for (int v = 0; v < 7; v++) begin
      ren   = vecs[v].ren;
      rwen  = vecs[v].rwen;
      radr  = vecs[v].radr;
      rwadr = vecs[v].rwadr;
      step();
      check($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_r));
      check($sformatf("vec%0d_rwdata", v), 32'(rwdata), 32'(vecs[v].exp_rw));
    end

    // Load N+1 words: the extra word wraps onto address 0
    load = 1'b1;
    for (int i = 0; i <= N; i++) begin
      wdata_valid = 1'b1;
      wdata_in    = (i < N) ? model[i] : 16'hBEEF;
      step();
    end
    wdata_valid = 1'b0;
    load = 1'b0;
    check("reload_hold_rdata", 32'(rdata), 32'(model[1]));
    model[0] = 16'hBEEF;
    ren   = 1'b1;
    rwen  = 1'b1;
    radr  = 12'h000;
    rwadr = 12'h001;
    step();
    check("wrap_adr0", 32'(rdata), 32'hBEEF);
    check("wrap_adr1", 32'(rwdata), 32'(model[1]));
    radr  = 12'hFFF;
    rwadr = 12'h800;
    step();
    check("wrap_adrfff", 32'(rdata), 32'(model[12'hFFF]));
    check("wrap_adr800", 32'(rwdata), 32'(model[12'h800]));

    // Reset in the middle of a load
    ren  = 1'b0;
    rwen = 1'b0;
    load = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wdata_valid = 1'b1;
      wdata_in    = 16'hA000 + 16'(k);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("async_reset_rdata", 32'(rdata), 32'h0);
    check("async_reset_rwdata", 32'(rwdata), 32'h0);
    step();
    rst_n = 1'b1;
    debug = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wdata_valid     = 1'b1;
      wdata_in        = 16'hC000 + 16'(k);
      debug_read_trig = 1'b1;
      step();
    end
    check("load_over_debug_hold", 32'(rdata), 32'h0);
    load            = 1'b0;
    wdata_valid     = 1'b0;
    debug_read_trig = 1'b0;
    step();
    step();
    check("trig_ignored_in_load", 32'(rdata), 32'hC000);
    debug = 1'b0;
    ren   = 1'b1;
    rwen  = 1'b1;
    radr  = 12'h001;
    rwadr = 12'h002;
    step();
    check("post_reset_adr1", 32'(rdata), 32'hC001);
    check("post_reset_adr2", 32'(rwdata), 32'hC002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_vec_sram_ctrl.md
Name: phase_vec_sram_ctrl

Overview:
- Controller for the phase-vector / transfer-function coefficient input SRAM: 2*DEPTH words of DATA_WIDTH bits, stored as two banks of DEPTH words.
- Three modes:
  - Load: sequential writes from a deserializer.
  - Debug: sequential readback into a serializer.
  - Normal: dual-port random reads for the IIR deconvolution kernel estimator.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 12, address width; equals log2(DEPTH)+1. The MSB selects the bank and the lower bits index within the bank.
- DEPTH, 2048, words per bank. Total capacity is 2*DEPTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- debug  in  1  debug readback mode enable.
- debug_read_trig  in  1  one-cycle pulse from the serializer: current word consumed, advance to the next.
- load  in  1  load mode enable.
- wdata_valid  in  1  wdata_in holds a complete word this cycle.
- wdata_in  in  DATA_WIDTH  load write data.
- ren  in  1  normal-mode read enable, R/O port.
- rwen  in  1  normal-mode read enable, R/W port.
- radr  in  ADDR_WIDTH  normal-mode R/O port address.
- rwadr  in  ADDR_WIDTH  normal-mode R/W port address.
- rdata  out  DATA_WIDTH  R/O port read data; also debug readback data.
- rwdata  out  DATA_WIDTH  R/W port read data.

Behaviour:
- Reset (async, rst_n=0):
  - rdata=0, rwdata=0.
  - Write pointer=0, debug pointer=0.
  - Memory contents are not cleared.
- Mode priority: load > debug > normal. Exactly one mode acts per cycle.
- Load mode (load=1):
  - On each rising edge with wdata_valid=1: mem[wptr] <= wdata_in, then wptr <= wptr+1.
  - wptr wraps from 2*DEPTH-1 to 0.
  - Writes use the R/W port. rdata and rwdata hold.
  - While load=0, wptr is held at 0, so every load session starts at address 0.
- Debug mode (load=0, debug=1):
  - The R/O port reads mem[dptr] every cycle: rdata <= mem[dptr], one-cycle latency.
  - On a rising edge with debug_read_trig=1: dptr <= dptr+1, wrapping after 2*DEPTH-1. rdata shows the new word on the following edge.
  - rwdata holds.
  - While debug=0, dptr is held at 0.
  - The serializer is enabled two cycles after debug rises, so rdata=mem[0] is stable before its first capture.
- Normal mode (load=0, debug=0):
  - ren=1: rdata <= mem[radr] at the rising edge, so data is valid after that edge (1-cycle latency).
  - rwen=1: rwdata <= mem[rwadr] likewise.
  - A disabled port holds its last output.
  - Both ports may address the same word or the same bank in the same cycle; both return correct data.
- Address mapping: bank = adr[ADDR_WIDTH-1], row = adr[ADDR_WIDTH-2:0]. Each bank supports one read plus one read/write per cycle.
- Simultaneous events:
  - wdata_valid while load=0 is ignored.
  - debug_read_trig while debug=0 or load=1 is ignored.
  - Mode switches take effect on the next edge; pointers reset to 0 in the cycle after their enable drops.
- Reset mid-operation: outputs and pointers clear immediately. Memory is retained but must be treated as undefined after reset.
- rwen is a read enable only; there is no external write path other than load mode.

Test Plan:
- Reset → rdata=0, rwdata=0. Then load=1 with 4096 random words at 1 word per 16 cycles → mem[i]=word i for all i in 0..4095.
- After the full load, load=0, debug=1, serializer on debug delayed 2 clocks → serial stream reproduces words 0..4095 LSB-first, no gaps or duplicates.
- Normal mode, ren=rwen=1, radr=i, rwadr=4095-i for i=0..4095 → on the cycle after each edge, rdata=word[i-1] and rwdata=word[4096-i].
- Load 4097 words → word 4096 overwrites address 0; other addresses unchanged.
- Both ports on the same address (radr=rwadr=0x805) → rdata==rwdata==mem[0x805]. Then ren=0 and change radr → rdata holds.
- Toggle debug off then on mid-stream → readback restarts at address 0. Assert rst_n=0 mid-load → wptr restarts at 0 after reset.
